// File: rtl/simpleadder_driver.sv
// rtl/simpleadder_driver.sv - valid/ready initiator that serializes operands to and deserializes sums from the 2-bit serial adder
module simpleadder_driver #(
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_a,
    input  logic [1:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_sum,
    output logic       rsp_err,
    output logic       en_i,
    output logic       ina,
    output logic       inb,
    input  logic       en_o,
    input  logic       out
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_MSB,
        SEND_LSB,
        WAIT_EN,
        RX1,
        RX0,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    a_q, a_d;
    logic [1:0]    b_q, b_d;
    logic [2:0]    sum_q, sum_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          live_q;
    logic          rsp_valid_q, rsp_valid_d;
    logic          en_i_q, en_i_d;
    logic          ina_q, ina_d;
    logic          inb_q, inb_d;

    // live_q keeps req_ready low until the first clock edge after reset release.
    assign req_ready = live_q && (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_err   = err_q;
    assign en_i      = en_i_q;
    assign ina       = ina_q;
    assign inb       = inb_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    sum_d   = 3'b000;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = SEND_MSB;
                end
            end
            SEND_MSB: state_d = SEND_LSB;
            SEND_LSB: state_d = WAIT_EN;
            WAIT_EN: begin
                if (en_o) begin
                    sum_d[2] = out;
                    state_d  = RX1;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    sum_d   = 3'b000;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RX1: begin
                sum_d[1] = out;
                state_d  = RX0;
            end
            RX0: begin
                sum_d[0] = out;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin outputs are decoded from the next state so they are registered yet aligned with it.
        en_i_d      = (state_d == SEND_MSB);
        ina_d       = 1'b0;
        inb_d       = 1'b0;
        if (state_d == SEND_MSB) begin
            ina_d = a_d[1];
            inb_d = b_d[1];
        end else if (state_d == SEND_LSB) begin
            ina_d = a_d[0];
            inb_d = b_d[0];
        end
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= 2'b00;
            b_q         <= 2'b00;
            sum_q       <= 3'b000;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            live_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            en_i_q      <= 1'b0;
            ina_q       <= 1'b0;
            inb_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            live_q      <= 1'b1;
            rsp_valid_q <= rsp_valid_d;
            en_i_q      <= en_i_d;
            ina_q       <= ina_d;
            inb_q       <= inb_d;
        end
    end

endmodule

// File: tb/tb_simpleadder_driver.sv
// tb/tb_simpleadder_driver.sv - self-checking bench for simpleadder_driver with a behavioural serial adder and transaction model
module tb_simpleadder_driver;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_a = 2'b00;
    logic [1:0] req_b = 2'b00;
    logic       rdy_man = 1'b1;
    logic       rnd_on = 1'b0;
    logic       rnd_bit = 1'b0;
    logic       rsp_ready;
    logic       stuck = 1'b0;
    logic       ad_en = 1'b0;
    logic       ad_out = 1'b0;
    logic       st_en = 1'b0;
    logic       st_out = 1'b0;
    logic       en_o;
    logic       out;
    logic       req_ready;
    logic       rsp_valid;
    logic [2:0] rsp_sum;
    logic       rsp_err;
    logic       en_i;
    logic       ina;
    logic       inb;

    assign rsp_ready = rnd_on ? rnd_bit : rdy_man;
    assign en_o      = !stuck && (ad_en || st_en);
    assign out       = ad_out | st_out;

    simpleadder_driver #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .en_i      (en_i),
        .ina       (ina),
        .inb       (inb),
        .en_o      (en_o),
        .out       (out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Serial adder: takes MSB with en_i, LSB next cycle, returns a+b MSB-first with en_o on the first bit.
    logic [1:0] ad_a, ad_b;
    logic [2:0] ad_s;
    initial forever begin
        @(posedge clk);
        if (en_i === 1'b1) begin
            ad_a[1] = ina;
            ad_b[1] = inb;
            @(posedge clk);
            ad_a[0] = ina;
            ad_b[0] = inb;
            ad_s = {1'b0, ad_a} + {1'b0, ad_b};
            @(negedge clk); ad_en = 1'b1; ad_out = ad_s[2];
            @(negedge clk); ad_en = 1'b0; ad_out = ad_s[1];
            @(negedge clk); ad_out = ad_s[0];
            @(negedge clk); ad_out = 1'b0;
        end
    end

    always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    // Transaction model: one outstanding request, fixed latency, expected result from plain arithmetic.
    int         ecnt = 0;
    int         acc_e = 0;
    int         lat = 6;
    logic       pending = 1'b0;
    logic       ready_ok = 1'b0;
    logic [1:0] ma = 2'b00;
    logic [1:0] mb = 2'b00;
    int         msum = 0;
    int         merr = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            ready_ok <= 1'b0;
        end else begin
            ready_ok <= 1'b1;
            ecnt     <= ecnt + 1;
            if (pending && (ecnt - acc_e) >= lat && rsp_ready) begin
                pending <= 1'b0;
            end else if (!pending && ready_ok && req_valid) begin
                pending <= 1'b1;
                acc_e   <= ecnt;
                ma      <= req_a;
                mb      <= req_b;
                msum    <= stuck ? 0 : int'(req_a) + int'(req_b);
                merr    <= stuck ? 1 : 0;
                lat     <= stuck ? 3 + TIMEOUT : 6;
            end
        end
    end

    int ph;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_en_i", int'(en_i), 0);
            chk("rst_ina", int'(ina), 0);
            chk("rst_inb", int'(inb), 0);
        end else begin
            ph = ecnt - acc_e;
            chk("req_ready", int'(req_ready), int'(!pending && ready_ok));
            chk("en_i", int'(en_i), int'(pending && ph == 1));
            chk("ina", int'(ina), (pending && ph == 1) ? int'(ma[1]) : (pending && ph == 2) ? int'(ma[0]) : 0);
            chk("inb", int'(inb), (pending && ph == 1) ? int'(mb[1]) : (pending && ph == 2) ? int'(mb[0]) : 0);
            chk("rsp_valid", int'(rsp_valid), int'(pending && ph >= lat));
            if (pending && ph >= lat) begin
                chk("rsp_sum", int'(rsp_sum), msum);
                chk("rsp_err", int'(rsp_err), merr);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic send(input logic [1:0] a, input logic [1:0] b);
        bit ok = 0;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clk);
            if (req_ready) ok = 1;
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (!ok) chk("send_accept_timeout", 0, 1);
    endtask

    task automatic wait_valid(input int start, output int n);
        n = start;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rsp_valid_timeout", 0, 1);
    endtask

    task automatic finish_rsp();
        bit ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(posedge clk);
            if (rsp_valid && rsp_ready) ok = 1;
        end
        @(negedge clk);
        if (!ok) chk("rsp_handshake_timeout", 0, 1);
    endtask

    task automatic txn(input logic [1:0] a, input logic [1:0] b,
                       output int s, output int e, output int n);
        send(a, b);
        wait_valid(1, n);
        s = int'(rsp_sum);
        e = int'(rsp_err);
        finish_rsp();
    endtask

    int s, e, n;
    logic [1:0] ra, rb;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_rsp_sum", int'(rsp_sum), 0);
        chk("reset_rsp_err", int'(rsp_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(req_ready), 1);

        send(2'd3, 2'd3);
        chk("t33_en_c1", int'(en_i), 1);
        chk("t33_ina_c1", int'(ina), 1);
        chk("t33_inb_c1", int'(inb), 1);
        @(negedge clk);
        chk("t33_en_c2", int'(en_i), 0);
        chk("t33_ina_c2", int'(ina), 1);
        chk("t33_inb_c2", int'(inb), 1);
        wait_valid(2, n);
        chk("t33_latency", n, 6);
        chk("t33_sum", int'(rsp_sum), 6);
        chk("t33_err", int'(rsp_err), 0);
        finish_rsp();

        for (int i = 0; i < 16; i++) begin
            txn(2'(i >> 2), 2'(i & 3), s, e, n);
            chk("sweep_sum", s, (i >> 2) + (i & 3));
            chk("sweep_err", e, 0);
            chk("sweep_latency", n, 6);
        end

        rdy_man = 1'b0;
        send(2'd1, 2'd2);
        wait_valid(1, n);
        chk("hold_sum0", int'(rsp_sum), 3);
        for (int k = 0; k < 5; k++) begin
            st_en  = (k == 1);
            st_out = (k == 1);
            @(negedge clk);
            chk("hold_valid", int'(rsp_valid), 1);
            chk("hold_sum", int'(rsp_sum), 3);
            chk("hold_req_ready", int'(req_ready), 0);
        end
        st_en = 1'b0;
        st_out = 1'b0;
        rdy_man = 1'b1;
        finish_rsp();
        chk("hold_released_ready", int'(req_ready), 1);

        stuck = 1'b1;
        txn(2'd2, 2'd1, s, e, n);
        chk("stuck_err", e, 1);
        chk("stuck_sum", s, 0);
        chk("stuck_latency", n, 3 + TIMEOUT);
        stuck = 1'b0;
        txn(2'd1, 2'd1, s, e, n);
        chk("after_stuck_sum", s, 2);
        chk("after_stuck_err", e, 0);

        st_en = 1'b1;
        st_out = 1'b1;
        @(negedge clk);
        st_en = 1'b0;
        st_out = 1'b0;
        @(negedge clk);
        chk("stray_idle_ready", int'(req_ready), 1);
        chk("stray_idle_valid", int'(rsp_valid), 0);

        send(2'd3, 2'd2);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", int'(req_ready), 0);
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        chk("midrst_rsp_sum", int'(rsp_sum), 0);
        chk("midrst_rsp_err", int'(rsp_err), 0);
        chk("midrst_en_i", int'(en_i), 0);
        chk("midrst_ina_inb", int'({ina, inb}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txn(2'd0, 2'd3, s, e, n);
        chk("post_rst_sum", s, 3);
        chk("post_rst_err", e, 0);

        rnd_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            stuck = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            txn(ra, rb, s, e, n);
            stuck = 1'b0;
        end
        rnd_on = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
